// File: rtl/bus_rr_router.sv
// Shared-bus round-robin arbiter and packet router: grants one source per
// transaction, pops its head packet and pushes it to the addressed receiver(s).
module bus_rr_router #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic [3:0]               grant_id,
    output logic                     busy,
    output logic                     err_drop,
    output logic [15:0]              pkt_cnt
);

    typedef enum logic [1:0] {IDLE, READ, PUSH} state_t;

    localparam logic [drvrs-1:0] ONE  = drvrs'(1);
    localparam logic [7:0]       NDEV = 8'(drvrs);
    localparam logic [4:0]       NDW  = 5'(drvrs);

    state_t               state, state_nx;
    logic [3:0]           last;
    logic [3:0]           winner;
    logic                 found;
    logic [4:0]           start, off, sum;
    logic [2*drvrs-1:0]   dbl, rot;
    logic [drvrs-1:0]     gsel;
    logic                 rd_ok;
    logic                 deliver;
    logic [pckg_sz-1:0]   head;
    logic [7:0]           dest;

    // Rotate the request vector so bit 0 is the device after 'last', then
    // take the lowest set bit and map it back to an absolute index.
    always_comb begin
        start = {1'b0, last} + 5'd1;
        dbl   = {pndng, pndng};
        rot   = dbl >> start;
        found = 1'b0;
        off   = '0;
        for (int j = 0; j < drvrs; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = 5'(j);
            end
        end
        sum = start + off;
        if (sum >= NDW) sum = sum - NDW;
        if (sum >= NDW) sum = sum - NDW;
        winner = sum[3:0];
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < drvrs; i++)
            if (grant_id == 4'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
    end

    assign gsel  = ONE << grant_id;
    assign rd_ok = (pndng & gsel) != '0;
    assign dest  = D_push[pckg_sz-1 -: 8];
    assign busy  = (state != IDLE);

    always_comb begin
        state_nx = state;
        pop      = '0;
        push     = '0;
        err_drop = 1'b0;
        deliver  = 1'b0;
        case (state)
            IDLE: if (found) state_nx = READ;
            READ: begin
                if (rd_ok) begin
                    pop      = gsel;
                    state_nx = PUSH;
                end else begin
                    state_nx = IDLE;
                end
            end
            PUSH: begin
                state_nx = IDLE;
                if (dest == broadcast) begin
                    push    = ~gsel;
                    deliver = 1'b1;
                end else if (dest < NDEV) begin
                    push    = ONE << dest;
                    deliver = 1'b1;
                end else begin
                    err_drop = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Reset wins in its own cycle: an in-flight packet is discarded.
        if (reset) begin
            pop      = '0;
            push     = '0;
            err_drop = 1'b0;
            deliver  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            last     <= 4'(drvrs-1);
            D_push   <= '0;
            pkt_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                grant_id <= winner;
                last     <= winner;
            end
            // D_push doubles as the packet register, so it holds outside PUSH.
            if (state == READ && rd_ok) D_push <= head;
            if (deliver) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bus_rr_router.sv
// Scoreboard bench for bus_rr_router: expected pushes are queued when a pop
// is seen/driven and compared when the router produces its PUSH cycle.
module tb_bus_rr_router;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   pop, push;
    logic [W-1:0]   D_push;
    logic [3:0]     grant_id;
    logic           busy, err_drop;
    logic [15:0]    pkt_cnt;

    typedef struct {
        logic [3:0]  push;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          nchk = 0;
    int          nerr = 0;
    logic [15:0] exp_cnt;

    bus_rr_router #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push), .grant_id(grant_id),
        .busy(busy), .err_drop(err_drop), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(int src, logic [15:0] d);
        exp_t e;
        e.data = d;
        e.err  = 1'b0;
        e.push = '0;
        if (d[15:8] == 8'hFF)   e.push = 4'hF & ~(4'b1 << src);
        else if (d[15:8] < 8'd4) e.push = 4'b1 << d[15:8];
        else                     e.err = 1'b1;
        return e;
    endfunction

    task automatic set_pkt(int dev, logic [15:0] d);
        D_pop[dev*W +: W] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_cnt = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nchk++;
        if ({pop, push, D_push, grant_id, busy, err_drop, pkt_cnt} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got pop=%b push=%b D_push=%h gid=%0d busy=%b err=%b cnt=%0d, want all 0",
                     pop, push, D_push, grant_id, busy, err_drop, pkt_cnt);
        end
    endtask

    task automatic test_single();
        exp_t e;
        pndng = 4'b0100;
        set_pkt(2, 16'h01AB);
        sb.push_back(model(2, 16'h01AB));
        exp_cnt++;
        @(negedge clk);
        nchk++;
        if (pop !== 4'b0100 || grant_id !== 4'd2 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL single_read: got pop=%b gid=%0d busy=%b, want 0100/2/1", pop, grant_id, busy);
        end
        @(negedge clk);
        pndng = '0;
        nchk++;
        e = sb.pop_front();
        if (push !== e.push || D_push !== e.data || err_drop !== e.err) begin
            nerr++;
            $display("FAIL single_push: got push=%b D=%h err=%b, want %b/%h/%b",
                     push, D_push, err_drop, e.push, e.data, e.err);
        end
        @(negedge clk);
        nchk++;
        if (pkt_cnt !== exp_cnt || busy !== 1'b0 || push !== '0) begin
            nerr++;
            $display("FAIL single_after: got cnt=%0d busy=%b push=%b, want %0d/0/0", pkt_cnt, busy, push, exp_cnt);
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        int   mlast, g, cyc, lastpop, npush;
        bit   first;
        do_reset();
        for (int i = 0; i < N; i++) set_pkt(i, {8'((i + 1) % N), 8'(8'h10 + i)});
        pndng   = 4'hF;
        mlast   = N - 1;
        first   = 1'b1;
        npush   = 0;
        cyc     = 0;
        lastpop = 0;
        while (npush < 12 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (pop !== '0) begin
                g = (mlast + 1) % N;
                nchk++;
                if (pop !== 4'(1 << g)) begin
                    nerr++;
                    $display("FAIL fair_order: got pop=%b, want %b", pop, 4'(1 << g));
                end
                if (!first) begin
                    nchk++;
                    if (cyc - lastpop != 3) begin
                        nerr++;
                        $display("FAIL fair_spacing: got %0d cycles between pops, want 3", cyc - lastpop);
                    end
                end
                first   = 1'b0;
                lastpop = cyc;
                e = model(g, D_pop[g*W +: W]);
                sb.push_back(e);
                if (!e.err) exp_cnt++;
                mlast = g;
            end
            if (push !== '0 || err_drop === 1'b1) begin
                nchk++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL fair_unexpected: got push=%b with empty scoreboard, want none", push);
                end else begin
                    e = sb.pop_front();
                    if (push !== e.push || D_push !== e.data || err_drop !== e.err) begin
                        nerr++;
                        $display("FAIL fair_push: got push=%b D=%h err=%b, want %b/%h/%b",
                                 push, D_push, err_drop, e.push, e.data, e.err);
                    end
                end
                npush++;
            end
        end
        pndng = '0;
        nchk++;
        if (npush != 12) begin
            nerr++;
            $display("FAIL fair_timeout: got %0d pushes, want 12", npush);
        end
        @(negedge clk);
        nchk++;
        if (pkt_cnt !== exp_cnt) begin
            nerr++;
            $display("FAIL fair_count: got cnt=%0d, want %0d", pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_broadcast();
        exp_t e;
        pndng = 4'b0010;
        set_pkt(1, 16'hFF55);
        sb.push_back(model(1, 16'hFF55));
        exp_cnt++;
        @(negedge clk);
        nchk++;
        if (pop !== 4'b0010) begin
            nerr++;
            $display("FAIL bcast_pop: got pop=%b, want 0010", pop);
        end
        @(negedge clk);
        pndng = '0;
        nchk++;
        e = sb.pop_front();
        if (push !== e.push || D_push !== e.data || err_drop !== e.err) begin
            nerr++;
            $display("FAIL bcast_push: got push=%b D=%h err=%b, want %b/%h/%b",
                     push, D_push, err_drop, e.push, e.data, e.err);
        end
        @(negedge clk);
        nchk++;
        if (push !== '0 || pkt_cnt !== exp_cnt || D_push !== 16'hFF55) begin
            nerr++;
            $display("FAIL bcast_after: got push=%b cnt=%0d D=%h, want 0/%0d/ff55", push, pkt_cnt, D_push, exp_cnt);
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        pndng = 4'b1000;
        set_pkt(3, 16'h0712);
        sb.push_back(model(3, 16'h0712));
        @(negedge clk);
        nchk++;
        if (pop !== 4'b1000) begin
            nerr++;
            $display("FAIL inval_pop: got pop=%b, want 1000", pop);
        end
        @(negedge clk);
        pndng = '0;
        nchk++;
        e = sb.pop_front();
        if (push !== e.push || err_drop !== e.err) begin
            nerr++;
            $display("FAIL inval_push: got push=%b err=%b, want %b/%b", push, err_drop, e.push, e.err);
        end
        @(negedge clk);
        nchk++;
        if (err_drop !== 1'b0 || pkt_cnt !== exp_cnt) begin
            nerr++;
            $display("FAIL inval_after: got err=%b cnt=%0d, want 0/%0d", err_drop, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_abort();
        pndng = 4'b0001;
        set_pkt(0, 16'h0105);
        @(negedge clk);
        pndng = '0;
        #1;
        nchk++;
        if (pop !== '0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL abort_read: got pop=%b busy=%b, want 0000/1", pop, busy);
        end
        @(negedge clk);
        nchk++;
        if (busy !== 1'b0 || push !== '0 || err_drop !== 1'b0) begin
            nerr++;
            $display("FAIL abort_idle: got busy=%b push=%b err=%b, want 0/0000/0", busy, push, err_drop);
        end
        @(negedge clk);
        nchk++;
        if (pkt_cnt !== exp_cnt || push !== '0) begin
            nerr++;
            $display("FAIL abort_count: got cnt=%0d push=%b, want %0d/0000", pkt_cnt, push, exp_cnt);
        end
    endtask

    task automatic test_reset_in_push();
        pndng = 4'b0010;
        set_pkt(1, 16'h0277);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        pndng = '0;
        #1;
        nchk++;
        if (push !== '0) begin
            nerr++;
            $display("FAIL rstpush_same: got push=%b, want 0000", push);
        end
        @(negedge clk);
        exp_cnt = '0;
        nchk++;
        if ({pop, push, D_push, grant_id, busy, err_drop, pkt_cnt} !== '0) begin
            nerr++;
            $display("FAIL rstpush_outputs: got pop=%b push=%b D=%h gid=%0d busy=%b err=%b cnt=%0d, want all 0",
                     pop, push, D_push, grant_id, busy, err_drop, pkt_cnt);
        end
        reset = 1'b0;
        pndng = 4'hF;
        for (int i = 0; i < N; i++) set_pkt(i, 16'h0000);
        @(negedge clk);
        nchk++;
        if (pop !== 4'b0001 || grant_id !== 4'd0) begin
            nerr++;
            $display("FAIL rstpush_first: got pop=%b gid=%0d, want 0001/0", pop, grant_id);
        end
        pndng = '0;
        repeat (2) @(negedge clk);
        nchk++;
        if (busy !== 1'b0 || pkt_cnt !== exp_cnt) begin
            nerr++;
            $display("FAIL rstpush_drain: got busy=%b cnt=%0d, want 0/%0d", busy, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        force dut.pkt_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_cnt;
        exp_cnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            pndng = 4'b0100;
            set_pkt(2, 16'h0011);
            sb.push_back(model(2, 16'h0011));
            exp_cnt++;
            repeat (2) @(negedge clk);
            pndng = '0;
            nchk++;
            if (push === '0) begin
                nerr++;
                $display("FAIL wrap_nopush: got push=%b, want a push", push);
            end else begin
                e = sb.pop_front();
                if (push !== e.push || D_push !== e.data) begin
                    nerr++;
                    $display("FAIL wrap_push: got push=%b D=%h, want %b/%h", push, D_push, e.push, e.data);
                end
            end
            @(negedge clk);
            nchk++;
            if (pkt_cnt !== exp_cnt) begin
                nerr++;
                $display("FAIL wrap_count: got cnt=%h, want %h", pkt_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        pndng   = '0;
        D_pop   = '0;
        exp_cnt = '0;
        test_reset();
        test_single();
        test_fairness();
        test_broadcast();
        test_invalid();
        test_abort();
        test_reset_in_push();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
